// File: rtl/jk_count_ctrl.sv
// jk_count_ctrl: command-driven sequencer for an external bank of WIDTH
// posedge JK flip-flops. Turns host commands (clear, preset, load, toggle,
// count up/down N steps) into per-cycle j/k/prn/clrn drive, with q fed back.
//
// Ports
//   clk        rising-edge clock, shared with the JK bank
//   clrn       synchronous active-low reset (also clears the bank)
//   cmd_valid  command present
//   cmd_ready  controller can accept a command (IDLE and out of reset)
//   cmd_op     0 NOP, 1 CLEAR, 2 PRESET, 3 LOAD, 4 UP, 5 DOWN, 6 TOGGLE, 7 rsvd
//   cmd_data   LOAD value
//   cmd_steps  step count for UP/DOWN
//   q_fb       q outputs of the bank
//   jk_j/jk_k  j/k inputs of the bank
//   jk_prn     active-low preset to the bank
//   jk_clrn    active-low clear to the bank
//   busy       command in progress
//   done       one-cycle completion pulse
//   wrap       one-cycle pulse after a count step that wrapped
//
// state | meaning
// IDLE  | bank held, cmd_ready=1, waiting for a command
// EXEC  | one-cycle drive for CLEAR/PRESET/LOAD/TOGGLE (hold for NOP/rsvd/zero-step)
// RUN   | counting; one bank step per cycle until the step counter reaches 1
// DONE  | done=1 for one cycle, bank held, then IDLE

module jk_count_ctrl #(
   parameter int WIDTH = 4,
   parameter int STEPW = 8
) (
   input  logic             clk,
   input  logic             clrn,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [2:0]       cmd_op,
   input  logic [WIDTH-1:0] cmd_data,
   input  logic [STEPW-1:0] cmd_steps,
   input  logic [WIDTH-1:0] q_fb,
   output logic [WIDTH-1:0] jk_j,
   output logic [WIDTH-1:0] jk_k,
   output logic [WIDTH-1:0] jk_prn,
   output logic [WIDTH-1:0] jk_clrn,
   output logic             busy,
   output logic             done,
   output logic             wrap
);

   localparam logic [2:0] OP_CLEAR  = 3'd1;
   localparam logic [2:0] OP_PRESET = 3'd2;
   localparam logic [2:0] OP_LOAD   = 3'd3;
   localparam logic [2:0] OP_UP     = 3'd4;
   localparam logic [2:0] OP_DOWN   = 3'd5;
   localparam logic [2:0] OP_TOGGLE = 3'd6;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_RUN  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [2:0]       op_q, op_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic [STEPW-1:0] cnt_q, cnt_d;
   logic             wrap_q, wrap_d;
   logic [WIDTH-1:0] tog;

   always_ff @(posedge clk) begin
      if (!clrn) begin
         state_q <= S_IDLE;
         op_q    <= '0;
         data_q  <= '0;
         cnt_q   <= '0;
         wrap_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         data_q  <= data_d;
         cnt_q   <= cnt_d;
         wrap_q  <= wrap_d;
      end
   end

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      data_d  = data_q;
      cnt_d   = cnt_q;
      wrap_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (cmd_valid) begin
               op_d   = cmd_op;
               data_d = cmd_data;
               cnt_d  = cmd_steps;
               if ((cmd_op == OP_UP || cmd_op == OP_DOWN) && cmd_steps != '0)
                  state_d = S_RUN;
               else
                  state_d = S_EXEC;
            end
         end
         S_EXEC: state_d = S_DONE;
         S_RUN: begin
            // q_fb here is the value the bank holds just before this step.
            wrap_d = (op_q == OP_UP) ? (&q_fb) : ~(|q_fb);
            cnt_d  = cnt_q - STEPW'(1);
            if (cnt_q == STEPW'(1))
               state_d = S_DONE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Ripple toggle enables: bit i toggles when all lower bits are 1 (UP)
   // or all lower bits are 0 (DOWN).
   always_comb begin
      logic carry;
      carry = 1'b1;
      tog   = '0;
      for (int i = 0; i < WIDTH; i++) begin
         tog[i] = carry;
         carry  = carry & ((op_q == OP_DOWN) ? ~q_fb[i] : q_fb[i]);
      end
   end

   always_comb begin
      cmd_ready = 1'b0;
      busy      = (state_q != S_IDLE);
      done      = (state_q == S_DONE);
      wrap      = wrap_q;
      jk_j      = '0;
      jk_k      = '0;
      jk_prn    = '1;
      jk_clrn   = '1;
      if (!clrn) begin
         // Clear the bank on the same edge as the controller reset.
         jk_clrn = '0;
      end else begin
         case (state_q)
            S_IDLE: cmd_ready = 1'b1;
            S_EXEC: begin
               case (op_q)
                  OP_CLEAR:  jk_clrn = '0;
                  OP_PRESET: jk_prn  = '0;
                  OP_LOAD: begin
                     jk_j = data_q;
                     jk_k = ~data_q;
                  end
                  OP_TOGGLE: begin
                     jk_j = '1;
                     jk_k = '1;
                  end
                  default: ;
               endcase
            end
            S_RUN: begin
               jk_j = tog;
               jk_k = tog;
            end
            default: ;
         endcase
      end
   end

endmodule
